read_reg_resp: RTL and testbench

//  Response-side companion of the register-read command parser. Takes one register

---
 rtl/read_reg_resp_pkg.sv | 29 ++
 rtl/read_reg_resp_byte_shifter.sv | 36 +++
 rtl/read_reg_resp.sv | 125 ++++++++++++
 tb/tb_read_reg_resp.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/read_reg_resp_pkg.sv
// Shared constants for the register-read response framer: FSM states, header
// bytes and the byte-count helper used to size the id/data fields.
package read_reg_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ID,
    ST_DATA,
    ST_TERM
  } state_e;

  localparam logic [7:0] HDR_0 = 8'h24;  // '$'
  localparam logic [7:0] HDR_1 = 8'h72;  // 'r'
  localparam logic [7:0] HDR_2 = 8'h61;  // 'a'

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return HDR_0;
      2'd1:    return HDR_1;
      default: return HDR_2;
    endcase
  endfunction

endpackage

// File: rtl/read_reg_resp_byte_shifter.sv
// Loads a byte-aligned word and presents its top byte; shifts left one byte per
// accepted byte and flags when the byte on the output is the final one.
module read_reg_resp_byte_shifter #(
  parameter int NBYTES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [8*NBYTES-1:0]   i_word,
  input  logic                  i_shift,
  output logic [7:0]            o_byte,
  output logic                  o_last
);

  localparam int CW = $clog2(NBYTES + 1);

  logic [8*NBYTES-1:0] r_sh;
  logic [CW-1:0]       r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_word;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sh  <= r_sh << 8;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_byte = r_sh[8*NBYTES-1 -: 8];
  assign o_last = (r_cnt == CW'(NBYTES - 1));

endmodule

// File: rtl/read_reg_resp.sv
// Serializes one register read result into "$ra" | id | data | TERM_CHAR for
// the UART transmitter, one byte per valid/ready transfer.
module read_reg_resp
  import read_reg_resp_pkg::*;
#(
  parameter int         DATA_WORD = 32,
  parameter int         ID_WORD   = 8,
  parameter int         CMD_WORD  = 8,
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ID_WORD-1:0]   r_id,
  input  logic [DATA_WORD-1:0] r_data,
  input  logic                 r_valid,
  output logic [CMD_WORD-1:0]  tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 drop
);

  localparam int NID  = nbytes(ID_WORD);
  localparam int NDAT = nbytes(DATA_WORD);
  localparam int NSH  = NID + NDAT;
  // One counter serves both the 3 header bytes and the id bytes.
  localparam int CW   = $clog2(((NID > 3) ? NID : 3) + 1);

  state_e          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic            r_done, r_drop;
  logic            w_load, w_shift, w_xfer, w_sh_last;
  logic [7:0]      w_byte, w_sh_byte;
  logic [8*NID-1:0]  w_id_pad;
  logic [8*NDAT-1:0] w_dat_pad;

  always_comb begin
    w_id_pad                 = '0;
    w_id_pad[ID_WORD-1:0]    = r_id;
    w_dat_pad                = '0;
    w_dat_pad[DATA_WORD-1:0] = r_data;
  end

  read_reg_resp_byte_shifter #(.NBYTES(NSH)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_word  ({w_id_pad, w_dat_pad}),
    .i_shift (w_shift),
    .o_byte  (w_sh_byte),
    .o_last  (w_sh_last)
  );

  assign w_xfer = tx_valid && tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_done  <= (r_state == ST_TERM) && w_xfer;
      r_drop  <= r_valid && (r_state != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_byte     = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (r_valid) begin
          w_load     = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = ST_HDR;
        end
      end
      ST_HDR: begin
        w_byte = hdr_byte(r_cnt[1:0]);
        if (w_xfer) begin
          if (r_cnt == CW'(2)) begin
            w_cnt_nx   = '0;
            w_state_nx = ST_ID;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      ST_ID: begin
        w_byte = w_sh_byte;
        if (w_xfer) begin
          w_shift = 1'b1;
          if (r_cnt == CW'(NID - 1)) w_state_nx = ST_DATA;
          else                       w_cnt_nx   = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        w_byte = w_sh_byte;
        if (w_xfer) begin
          w_shift = 1'b1;
          if (w_sh_last) w_state_nx = ST_TERM;
        end
      end
      ST_TERM: begin
        w_byte = TERM_CHAR;
        if (w_xfer) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign tx_valid = (r_state != ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign tx_data  = CMD_WORD'(w_byte);
  assign done     = r_done;
  assign drop     = r_drop;

endmodule

// File: tb/tb_read_reg_resp.sv
// Scoreboard bench for read_reg_resp: default 32-bit data instance plus a
// 12-bit data instance for the zero-padding case.
module tb_read_reg_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  a_id = '0;
  logic [31:0] a_data = '0;
  logic        a_valid = 1'b0, a_ready = 1'b1;
  logic [7:0]  a_txd;
  logic        a_txv, a_busy, a_done, a_drop;

  logic [7:0]  b_id = '0;
  logic [11:0] b_data = '0;
  logic        b_valid = 1'b0, b_ready = 1'b1;
  logic [7:0]  b_txd;
  logic        b_txv, b_busy, b_done, b_drop;

  read_reg_resp u_dut (
    .clk(clk), .rst(rst), .r_id(a_id), .r_data(a_data), .r_valid(a_valid),
    .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(a_ready),
    .busy(a_busy), .done(a_done), .drop(a_drop)
  );

  read_reg_resp #(.DATA_WORD(12)) u_dut12 (
    .clk(clk), .rst(rst), .r_id(b_id), .r_data(b_data), .r_valid(b_valid),
    .tx_data(b_txd), .tx_valid(b_txv), .tx_ready(b_ready),
    .busy(b_busy), .done(b_done), .drop(b_drop)
  );

  int n_cmp = 0, n_err = 0;
  byte unsigned qa[$], qb[$];
  int xa[$];
  int n_drop = 0;
  int rdy_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Every valid byte must equal the queue head, held or not.
  always @(negedge clk) if (!rst) begin
    if (a_txv) begin
      if (qa.size() == 0) chk("a_extra", qa.size(), 1);
      else begin
        chk("a_byte", a_txd, qa[0]);
        if (a_ready) begin
          void'(qa.pop_front());
          xa.push_back(cyc);
        end
      end
    end
    if (a_drop) n_drop++;
    if (b_txv) begin
      if (qb.size() == 0) chk("b_extra", qb.size(), 1);
      else begin
        chk("b_byte", b_txd, qb[0]);
        if (b_ready) void'(qb.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 1) a_ready = (cyc % 3 == 0);
  end

  task automatic push_a(input logic [7:0] id, input logic [31:0] d);
    qa.push_back(8'h24); qa.push_back(8'h72); qa.push_back(8'h61);
    qa.push_back(id);
    qa.push_back(d[31:24]); qa.push_back(d[23:16]);
    qa.push_back(d[15:8]);  qa.push_back(d[7:0]);
    qa.push_back(8'h0A);
  endtask

  task automatic send_a(input logic [7:0] id, input logic [31:0] d, output int k0);
    @(posedge clk); #1;
    a_id = id; a_data = d; a_valid = 1'b1;
    push_a(id, d);
    @(posedge clk); #1;
    a_valid = 1'b0;
    k0 = cyc;
  endtask

  task automatic wait_done_a(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (a_done) begin dc = cyc; break; end
    end
    if (dc < 0) chk("a_done_timeout", a_done, 1);
  endtask

  task automatic send_b(input logic [7:0] id, input logic [11:0] d);
    logic [15:0] pad;
    int seen;
    pad = {4'h0, d};
    @(posedge clk); #1;
    b_id = id; b_data = d; b_valid = 1'b1;
    qb.push_back(8'h24); qb.push_back(8'h72); qb.push_back(8'h61);
    qb.push_back(id); qb.push_back(pad[15:8]); qb.push_back(pad[7:0]);
    qb.push_back(8'h0A);
    @(posedge clk); #1;
    b_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_done) begin seen = 1; break; end
    end
    if (seen == 0) chk("b_done_timeout", b_done, 1);
    chk("b_q_empty", qb.size(), 0);
  endtask

  initial begin
    int k0, dc, dc2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txv", a_txv, 0);
    chk("rst_txd", a_txd, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_drop", a_drop, 0);
    chk("rst_b_txv", b_txv, 0);
    rst = 1'b0;

    // 1: full-rate frame, exact cycle positions
    xa.delete();
    send_a(8'h05, 32'hDEADBEEF, k0);
    wait_done_a(50, dc);
    chk("t1_done_cyc", dc, k0 + 9);
    chk("t1_busy_at_done", a_busy, 0);
    chk("t1_nxfer", xa.size(), 9);
    for (int i = 0; i < 9 && i < xa.size(); i++) chk("t1_xfer_cyc", xa[i], k0 + i);

    // 2: throttled ready, same bytes, stability via queue-head check
    rdy_mode = 1;
    send_a(8'h05, 32'hDEADBEEF, k0);
    wait_done_a(200, dc);
    rdy_mode = 0;
    @(posedge clk); #1;
    a_ready = 1'b1;
    chk("t2_q_empty", qa.size(), 0);

    // 3: r_valid while busy is dropped
    xa.delete();
    n_drop = 0;
    send_a(8'h05, 32'hDEADBEEF, k0);
    repeat (2) @(posedge clk);
    #1;
    a_id = 8'h06; a_data = 32'h12345678; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    wait_done_a(50, dc);
    repeat (15) @(negedge clk);
    chk("t3_drop_cnt", n_drop, 1);
    chk("t3_nxfer", xa.size(), 9);
    chk("t3_q_empty", qa.size(), 0);

    // 4: back-to-back on the done cycle
    xa.delete();
    send_a(8'h11, 32'hCAFEF00D, k0);
    wait_done_a(50, dc);
    a_id = 8'h22; a_data = 32'h0BADC0DE; a_valid = 1'b1;
    push_a(8'h22, 32'h0BADC0DE);
    @(posedge clk); #1;
    a_valid = 1'b0;
    wait_done_a(50, dc2);
    chk("t4_nxfer", xa.size(), 18);
    if (xa.size() >= 10) chk("t4_b2b_start", xa[9], dc + 1);
    chk("t4_done2_cyc", dc2, dc + 10);

    // 5: async reset during DATA byte 2
    send_a(8'h33, 32'h01020304, k0);
    repeat (6) @(negedge clk);
    chk("t5_pre_byte", a_txd, 8'h02);
    #2 rst = 1'b1;
    #1;
    chk("t5_txv", a_txv, 0);
    chk("t5_txd", a_txd, 0);
    chk("t5_busy", a_busy, 0);
    chk("t5_done", a_done, 0);
    chk("t5_drop", a_drop, 0);
    qa.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send_a(8'h44, 32'hA5A55A5A, k0);
    wait_done_a(50, dc);
    chk("t5_q_empty", qa.size(), 0);

    // 6: 12-bit data zero-padded to two bytes
    send_b(8'h07, 12'hABC);
    send_b(8'h08, 12'h00F);

    repeat (5) @(negedge clk);
    chk("end_qa_empty", qa.size(), 0);
    chk("end_qb_empty", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
